led_delay_sequencer: RTL and testbench
======================================

# led_delay_sequencer

Sequencing controller for the `clktick` tick generator in the reaction-timer datapath. It gates the tick generator's `enable` and lights a bank of LEDs left-to-right, one per tick. It then waits a pseudo-random number of further ticks and emits a single-cycle `time_out` pulse, which starts the downstream reaction counter. It sits between the push-button conditioning logic and the `clktick` instance (typically N = 49999 at 50 MHz for 1 ms ticks).

## Interface
- `N_LED`, default 10: number of LEDs lit in sequence; 1..16.
- `LFSR_W`, default 7: width of the random-delay LFSR and delay counter; fixed polynomial below assumes 7.
- `SEED`, default 7'h01: LFSR reset value; must be nonzero.

Ports:
- `clkin`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `trigger`  in  1  start request, level-sampled; ignored while `busy`.
- `abort`  in  1  cancel the current sequence; ignored in IDLE.
- `tick`  in  1  one-cycle pulse from `clktick`.
- `tick_en`  out  1  drives `clktick` `enable`.
- `ledr`  out  N_LED  LED bar; bit 0 lights first.
- `delay_q`  out  LFSR_W  random delay (in ticks) captured for the current run.
- `busy`  out  1  high in any state other than IDLE.
- `time_out`  out  1  one-cycle pulse at the end of the random wait.

## Operation
- All outputs are registered. Reset values: state IDLE, `tick_en`=0, `ledr`=0, `delay_q`=0, `busy`=0, `time_out`=0, LFSR=SEED, delay counter 0.
- LFSR behaviour:
  - Fibonacci form, x^7+x^6+1, maximal length 127.
  - Shift: `next = {lfsr[5:0], lfsr[6]^lfsr[5]}`.
  - Advances every clock when not in reset.
  - Never reaches 0, so the captured delay is always in 1..127.
- IDLE:
  - Outputs: `tick_en`=0, `busy`=0.
  - `trigger`=1 at an edge moves to LIGHT with `ledr`=0, `tick_en`=1, `busy`=1.
- LIGHT:
  - Each cycle with `tick`=1: `ledr <= {ledr[N_LED-2:0],1'b1}`.
  - On the tick where `ledr[N_LED-1]` becomes 1 (tick N_LED):
    - `delay_q` and the delay counter load the current LFSR value.
    - State moves to WAIT.
    - `ledr` stays all-ones.
- WAIT:
  - Each `tick` decrements the delay counter.
  - A `tick` with counter==1 moves to DONE: `ledr`<=0, `tick_en`<=0, `time_out`<=1.
- DONE:
  - Lasts exactly one cycle with `time_out`=1.
  - Next state is IDLE; `time_out`=0 and `busy`=0 there.
  - `delay_q` holds its value until the next capture.
- Abort:
  - `abort`=1 in LIGHT or WAIT moves to IDLE on the next edge.
  - `ledr`=0, `tick_en`=0, no `time_out`.
  - `abort` wins over a simultaneous final tick.
  - `abort` in DONE is ignored; the pulse still completes.
- `trigger` is ignored in LIGHT, WAIT and DONE, with no queuing. A `trigger` held high through DONE restarts from IDLE on the following edge.
- `rst` in any state forces reset values on the next edge and overrides every other input.

## Timing
- Trigger sampled at edge k: `busy`/`tick_en` are high after edge k. The first tick that counts is sampled at edge k+1 or later.
- A `tick` coincident with the `trigger` edge is not counted.
- Tick-to-LED latency: the LED bit is set on the same edge the `tick` is sampled.
- Total ticks from start to `time_out` = N_LED + `delay_q`.
- `time_out` rises on the edge sampling the final tick and falls one edge later.
- `tick` pulses outside LIGHT/WAIT have no effect.
- A `tick` held high for consecutive cycles counts once per cycle. The block does not edge-detect.

## Test plan
- Reset, then 127 clocks with no `trigger` -> all outputs 0 and the LFSR returns to 7'h01 after exactly 127 clocks.
- `trigger` pulse, `tick` every 4 cycles -> `ledr` steps 001, 003, ... 3FF over 10 ticks; `delay_q` equals the LFSR value at the 10th tick; `time_out` is a single pulse exactly `delay_q` ticks later; `busy` falls the cycle after.
- Force LFSR capture value 1 via SEED/timing -> `time_out` on the first WAIT tick (11 ticks total).
- `abort` asserted after the 5th tick -> `ledr`=0 and `tick_en`=0 next cycle; `time_out` never asserts; a new `trigger` restarts from `ledr`=0.
- `abort` and the final WAIT tick in the same cycle -> IDLE with no `time_out`. `trigger` pulses during LIGHT and WAIT -> ignored, and tick totals are unchanged.
- `rst` asserted mid-WAIT -> all outputs reach reset values on the next edge; `tick` pulses during `rst` are ignored.

Source files
------------

// File: rtl/led_delay_sequencer.sv
// Reaction-timer sequencer: gates the clktick enable, lights an LED bar one
// LED per tick, then waits a pseudo-random number of ticks before pulsing time_out.
module led_delay_sequencer #(
  parameter int                N_LED  = 10,
  parameter int                LFSR_W = 7,
  parameter logic [LFSR_W-1:0] SEED   = {{(LFSR_W-1){1'b0}}, 1'b1}
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              trigger,
  input  logic              abort,
  input  logic              tick,
  output logic              tick_en,
  output logic [N_LED-1:0]  ledr,
  output logic [LFSR_W-1:0] delay_q,
  output logic              busy,
  output logic              time_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LIGHT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]   cnt_q, cnt_d;
  logic [LFSR_W-1:0]   dly_q, dly_d;
  logic [N_LED-1:0]    ledr_q, ledr_d;
  logic                tick_en_q, tick_en_d;
  logic                busy_q, busy_d;
  logic                time_out_q, time_out_d;
  logic [N_LED-1:0]    led_shift;

  // Written as shift-or so a single-LED build needs no special case.
  assign led_shift = (ledr_q << 1) | N_LED'(1);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2]};
    cnt_d      = cnt_q;
    dly_d      = dly_q;
    ledr_d     = ledr_q;
    tick_en_d  = tick_en_q;
    busy_d     = busy_q;
    time_out_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        tick_en_d = 1'b0;
        busy_d    = 1'b0;
        if (trigger) begin
          state_d   = S_LIGHT;
          ledr_d    = '0;
          tick_en_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      S_LIGHT: begin
        if (abort) begin
          state_d   = S_IDLE;
          ledr_d    = '0;
          tick_en_d = 1'b0;
          busy_d    = 1'b0;
        end else if (tick) begin
          ledr_d = led_shift;
          if (led_shift[N_LED-1]) begin
            dly_d   = lfsr_q;
            cnt_d   = lfsr_q;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // Abort takes priority even over the tick that would end the wait.
        if (abort) begin
          state_d   = S_IDLE;
          ledr_d    = '0;
          tick_en_d = 1'b0;
          busy_d    = 1'b0;
        end else if (tick) begin
          if (cnt_q == LFSR_W'(1)) begin
            state_d    = S_DONE;
            ledr_d     = '0;
            tick_en_d  = 1'b0;
            time_out_d = 1'b1;
          end else begin
            cnt_d = cnt_q - LFSR_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, matching the hardware register behaviour.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      dly_q      <= '0;
      ledr_q     <= '0;
      tick_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      time_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
      ledr_q     <= ledr_d;
      tick_en_q  <= tick_en_d;
      busy_q     <= busy_d;
      time_out_q <= time_out_d;
    end
  end

  assign tick_en  = tick_en_q;
  assign ledr     = ledr_q;
  assign delay_q  = dly_q;
  assign busy     = busy_q;
  assign time_out = time_out_q;

endmodule

// File: tb/tb_led_delay_sequencer.sv
// Self-checking bench for led_delay_sequencer: scoreboard of captured delays,
// compared against the tick count at which time_out fires.
module tb_led_delay_sequencer;

  localparam int N_LED  = 10;
  localparam int LFSR_W = 7;

  logic              clkin = 1'b0;
  logic              rst = 1'b1;
  logic              trigger = 1'b0;
  logic              abort = 1'b0;
  logic              tick = 1'b0;
  logic              tick_en;
  logic [N_LED-1:0]  ledr;
  logic [LFSR_W-1:0] delay_q;
  logic              busy;
  logic              time_out;

  int                tests_run = 0;
  int                tests_failed = 0;
  logic [6:0]        exp_q[$];
  logic [6:0]        m_lfsr;

  always #5 clkin = ~clkin;

  led_delay_sequencer #(.N_LED(N_LED), .LFSR_W(LFSR_W), .SEED(7'h01)) dut (
    .clkin   (clkin),
    .rst     (rst),
    .trigger (trigger),
    .abort   (abort),
    .tick    (tick),
    .tick_en (tick_en),
    .ledr    (ledr),
    .delay_q (delay_q),
    .busy    (busy),
    .time_out(time_out)
  );

  // Reference LFSR: x^7 + x^6 + 1, seeded with 1, advancing every unreset clock.
  always @(posedge clkin) begin
    if (rst) m_lfsr <= 7'h01;
    else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion before 1000000");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clkin);
    #1;
  endtask

  // Trigger (optionally) then drive N_LED ticks; returns the LFSR value the DUT should capture.
  task automatic light_phase(input int period, input bit noise, input bit skip_trig,
                             input bit tick_on_trig, output logic [6:0] d);
    logic [N_LED-1:0] el;
    d = '0;
    if (!skip_trig) begin
      trigger = 1'b1; tick = tick_on_trig; cyc(); trigger = 1'b0; tick = 1'b0;
      tests_run++;
      if (busy !== 1'b1 || tick_en !== 1'b1 || ledr !== '0) begin
        tests_failed++;
        $display("FAIL start: busy=%b tick_en=%b ledr=%h, required busy=1 tick_en=1 ledr=000",
                 busy, tick_en, ledr);
      end
    end
    for (int i = 1; i <= N_LED; i++) begin
      for (int j = 1; j < period; j++) begin
        trigger = noise; cyc(); trigger = 1'b0;
      end
      tick = 1'b1;
      if (i == N_LED) d = m_lfsr;
      cyc(); tick = 1'b0;
      el = N_LED'((32'd1 << i) - 32'd1);
      tests_run++;
      if (ledr !== el || busy !== 1'b1 || tick_en !== 1'b1 || time_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL led_step%0d: ledr=%h busy=%b tick_en=%b time_out=%b, required ledr=%h 1 1 0",
                 i, ledr, busy, tick_en, time_out, el);
      end
    end
    tests_run++;
    if (delay_q !== d) begin
      tests_failed++;
      $display("FAIL capture: delay_q=%h, required %h", delay_q, d);
    end
  endtask

  // Drive WAIT ticks until time_out; pop scoreboard and compare tick count and delay.
  task automatic wait_phase(input int period, input bit noise, input bit hold_trig);
    int         wcnt = 0;
    bit         seen = 1'b0;
    logic [6:0] e;
    for (int k = 0; k < 140 && !seen; k++) begin
      for (int j = 1; j < period; j++) begin
        trigger = noise; cyc(); trigger = 1'b0;
        tests_run++;
        if (time_out !== 1'b0 || ledr !== '1 || busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL wait_idle: time_out=%b ledr=%h busy=%b, required 0 3ff 1",
                   time_out, ledr, busy);
        end
      end
      tick = 1'b1; cyc(); tick = 1'b0;
      wcnt++;
      if (time_out === 1'b1) begin
        seen = 1'b1;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_time_out: got pulse after %0d ticks, required none", wcnt);
        end else begin
          e = exp_q.pop_front();
          if (wcnt != int'(e) || delay_q !== e || ledr !== '0 || tick_en !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL time_out: ticks=%0d delay_q=%h ledr=%h tick_en=%b busy=%b, required ticks=%0d delay_q=%h 000 0 1",
                     wcnt, delay_q, ledr, tick_en, busy, e, e);
          end
        end
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL wait_timeout: time_out=0 after %0d ticks, required a pulse", wcnt);
    end
    trigger = hold_trig; cyc();
    tests_run++;
    if (time_out !== 1'b0 || busy !== 1'b0 || tick_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL pulse_end: time_out=%b busy=%b tick_en=%b, required 0 0 0", time_out, busy, tick_en);
    end
  endtask

  task automatic run_seq(input int period, input bit noise, input bit tick_on_trig);
    logic [6:0] d;
    light_phase(period, noise, 1'b0, tick_on_trig, d);
    exp_q.push_back(d);
    wait_phase(period, noise, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; trigger = 1'b0; abort = 1'b0; tick = 1'b0;
    cyc(); rst = 1'b0;
    tests_run++;
    if ({tick_en, ledr, delay_q, busy, time_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset: tick_en=%b ledr=%h delay_q=%h busy=%b time_out=%b, required all 0",
               tick_en, ledr, delay_q, busy, time_out);
    end
    // 117 idle clocks, stray ticks included; the LFSR keeps running underneath.
    for (int i = 0; i < 117; i++) begin
      tick = (i % 3 == 0); cyc(); tick = 1'b0;
      tests_run++;
      if ({tick_en, ledr, delay_q, busy, time_out} !== '0) begin
        tests_failed++;
        $display("FAIL idle%0d: tick_en=%b ledr=%h delay_q=%h busy=%b time_out=%b, required all 0",
                 i, tick_en, ledr, delay_q, busy, time_out);
      end
    end
  endtask

  // Trigger at clock 118 and ten back-to-back ticks: capture lands on clock 128,
  // when the LFSR has completed its 127-state period and is back at 7'h01.
  task automatic test_min_delay();
    logic [6:0] d;
    light_phase(1, 1'b0, 1'b0, 1'b0, d);
    tests_run++;
    if (delay_q !== 7'h01) begin
      tests_failed++;
      $display("FAIL lfsr_period: delay_q=%h, required 01", delay_q);
    end
    exp_q.push_back(7'h01);
    wait_phase(1, 1'b0, 1'b0);
  endtask

  task automatic test_main();
    run_seq(4, 1'b0, 1'b1);
  endtask

  task automatic test_trigger_ignored();
    run_seq(3, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    trigger = 1'b1; cyc(); trigger = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(); tick = 1'b1; cyc(); tick = 1'b0;
    end
    tests_run++;
    if (ledr !== N_LED'(10'h01f)) begin
      tests_failed++;
      $display("FAIL abort_pre: ledr=%h, required 01f", ledr);
    end
    abort = 1'b1; cyc(); abort = 1'b0;
    tests_run++;
    if (ledr !== '0 || tick_en !== 1'b0 || busy !== 1'b0 || time_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort: ledr=%h tick_en=%b busy=%b time_out=%b, required 000 0 0 0",
               ledr, tick_en, busy, time_out);
    end
    for (int i = 0; i < 30; i++) begin
      tick = i[0]; cyc(); tick = 1'b0;
      tests_run++;
      if (time_out !== 1'b0 || busy !== 1'b0 || ledr !== '0) begin
        tests_failed++;
        $display("FAIL abort_after%0d: time_out=%b busy=%b ledr=%h, required 0 0 000",
                 i, time_out, busy, ledr);
      end
    end
    run_seq(2, 1'b0, 1'b0);
  endtask

  task automatic test_abort_final();
    logic [6:0] d;
    light_phase(2, 1'b0, 1'b0, 1'b0, d);
    for (int w = 1; w < int'(d); w++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      tests_run++;
      if (time_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL abort_final_early%0d: time_out=%b, required 0", w, time_out);
      end
    end
    tick = 1'b1; abort = 1'b1; cyc(); tick = 1'b0; abort = 1'b0;
    tests_run++;
    if (time_out !== 1'b0 || busy !== 1'b0 || ledr !== '0 || tick_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_final: time_out=%b busy=%b ledr=%h tick_en=%b, required 0 0 000 0",
               time_out, busy, ledr, tick_en);
    end
    cyc();
    tests_run++;
    if (time_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_final_late: time_out=%b, required 0", time_out);
    end
  endtask

  // Trigger held through DONE is ignored there and starts a new run from IDLE.
  task automatic test_back_to_back();
    logic [6:0] d;
    light_phase(2, 1'b0, 1'b0, 1'b0, d);
    exp_q.push_back(d);
    wait_phase(2, 1'b0, 1'b1);
    cyc(); trigger = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || tick_en !== 1'b1 || ledr !== '0) begin
      tests_failed++;
      $display("FAIL restart: busy=%b tick_en=%b ledr=%h, required 1 1 000", busy, tick_en, ledr);
    end
    light_phase(2, 1'b0, 1'b1, 1'b0, d);
    exp_q.push_back(d);
    wait_phase(2, 1'b0, 1'b0);
  endtask

  task automatic test_rst_mid_wait();
    logic [6:0] d;
    light_phase(1, 1'b0, 1'b0, 1'b0, d);
    if (d > 7'd2) begin
      tick = 1'b1; cyc(); tick = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1; tick = 1'b1; trigger = 1'b1; cyc();
      tests_run++;
      if ({tick_en, ledr, delay_q, busy, time_out} !== '0) begin
        tests_failed++;
        $display("FAIL rst_mid%0d: tick_en=%b ledr=%h delay_q=%h busy=%b time_out=%b, required all 0",
                 i, tick_en, ledr, delay_q, busy, time_out);
      end
    end
    rst = 1'b0; trigger = 1'b0; tick = 1'b1; cyc(); tick = 1'b0;
    tests_run++;
    if ({tick_en, ledr, delay_q, busy, time_out} !== '0) begin
      tests_failed++;
      $display("FAIL rst_release: tick_en=%b ledr=%h delay_q=%h busy=%b time_out=%b, required all 0",
               tick_en, ledr, delay_q, busy, time_out);
    end
    run_seq(2, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_min_delay();
    test_main();
    test_trigger_ignored();
    test_abort();
    test_abort_final();
    test_back_to_back();
    test_rst_mid_wait();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
